fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one ieee754multiplier instance between NUM_REQ requesters.
- Grants one request at a time and drives the multiplier's start/operand inputs.
- Waits for done, then returns the product and exception flags to the granted requester, tagged with its index.
- A watchdog aborts a transaction if done never arrives.

Parameters:
- NUM_REQ, 4: number of requesters; 2..8.
- TIMEOUT_CYCLES, 64: maximum BUSY cycles before abort; must be >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid_i  in  NUM_REQ  bit k: requester k has an operand pair pending.
- req_a_i  in  32*NUM_REQ  operand A of requester k at bits [32k+31:32k].
- req_b_i  in  32*NUM_REQ  operand B, same packing.
- req_ready_o  out  NUM_REQ  one-hot, one-cycle pulse: operands of requester k captured.
- resp_valid_o  out  1  one-cycle pulse: result valid.
- resp_id_o  out  $clog2(NUM_REQ)  index of the requester owning the result.
- resp_product_o  out  32  product bits.
- resp_flags_o  out  5  {timeout, nan, infinit, overflow, underflow}.
- mul_start_o  out  1  to multiplier start_i.
- mul_a_o, mul_b_o  out  32 each  to multiplier a_i/b_i.
- mul_done_i  in  1  from multiplier done_o.
- mul_product_i  in  32  from multiplier product_o.
- mul_flags_i  in  4  {nan_o, inifinit_o, overflow_o, underflow_o}.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset, immediate and asynchronous:
  - state = IDLE, last_grant = NUM_REQ-1.
  - All outputs 0, including mul_a_o, mul_b_o, resp_id_o, resp_product_o, resp_flags_o.
  - Counter = 0.
- Reset mid-transaction drops the transaction silently. No resp_valid_o is emitted. The requester must re-request.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Grants only when mul_done_i == 0, so a stale done from a prior operation is never mistaken for completion.
  - If any req_valid_i bit is set, the grant g is the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - At that edge:
    - mul_a_o/mul_b_o latch requester g's operands.
    - req_ready_o[g] = 1 for exactly one cycle.
    - mul_start_o = 1; last_grant = g; resp_id_o = g; counter cleared.
    - state -> BUSY.
  - Operands are registered, so requesters may change req_a_i/req_b_i freely after the ready pulse.
- BUSY:
  - mul_start_o held 1; mul_a_o/mul_b_o held stable; counter increments each cycle.
  - Normal completion: on the first edge with mul_done_i == 1:
    - capture mul_product_i into resp_product_o;
    - resp_flags_o = {0, mul_flags_i};
    - mul_start_o = 0; state -> RESP.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 without done:
    - resp_product_o = 0; resp_flags_o = 5'b10000;
    - mul_start_o = 0; state -> RESP.
  - If done and timeout occur on the same edge, done wins (no timeout flag).
- RESP:
  - resp_valid_o = 1 for exactly one cycle; state -> IDLE.
  - resp_product_o, resp_flags_o and resp_id_o hold their values until the next capture.
- Latency: request visible at edge E0 in IDLE -> ready pulse after E0 -> resp_valid_o asserted D+1 cycles after E0, where D = multiplier done latency in cycles after start.
- Back-to-back grants: at least one IDLE cycle between transactions, and more if mul_done_i is still high.
- Fairness: a continuously requesting requester k waits at most NUM_REQ-1 transactions.
- Request withdrawn before grant: permitted; the arbiter only samples req_valid_i in IDLE.
- No acceptance outside IDLE: req_ready_o stays 0 in BUSY and RESP.

Test Plan:
- Single request:
  - Stimulus: req 0 only, a = 0x40F00000 (7.5), b = 0x400CCCCD (2.2); mock multiplier returns done 3 cycles after start with product 0x41840000, flags 0.
  - Required: one req_ready_o[0] pulse; mul_a_o = 0x40F00000 during BUSY; resp_valid_o 4 cycles after grant; resp_id_o = 0; resp_product_o = 0x41840000; resp_flags_o = 0.
- All four requesting continuously from reset:
  - Required: grant order 0,1,2,3,0,1; exactly one resp_valid_o per grant, with matching resp_id_o.
- Flag pass-through:
  - Stimulus: a = 0x7FC00000 (NaN); mock asserts nan_o.
  - Required: resp_flags_o = 5'b01000.
- Timeout:
  - Stimulus: mock never asserts done, TIMEOUT_CYCLES = 64.
  - Required: resp_valid_o after 64 BUSY cycles; resp_flags_o = 5'b10000; resp_product_o = 0; the next request is then granted normally.
- Stale done:
  - Stimulus: mul_done_i held high for 5 cycles after RESP while req 2 is pending.
  - Required: no grant until mul_done_i falls; req 2 is granted on the first IDLE edge with mul_done_i low.
- Reset mid-BUSY:
  - Stimulus: assert rst asynchronously between edges.
  - Required: mul_start_o and busy_o drop immediately; no resp_valid_o; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one IEEE-754 multiplier between NUM_REQ requesters.
// Grant is one edge after the request is seen in IDLE; the response follows D+1 edges later (D = multiplier latency).
module fp_mul_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [32*NUM_REQ-1:0]      req_a_i,
  input  logic [32*NUM_REQ-1:0]      req_b_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       resp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] resp_id_o,
  output logic [31:0]                resp_product_o,
  output logic [4:0]                 resp_flags_o,
  output logic                       mul_start_o,
  output logic [31:0]                mul_a_o,
  output logic [31:0]                mul_b_o,
  input  logic                       mul_done_i,
  input  logic [31:0]                mul_product_i,
  input  logic [3:0]                 mul_flags_i,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IDW-1:0]       r_last_grant;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_ready;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [IDW-1:0]       r_id;
  logic [31:0]          r_product;
  logic [4:0]           r_flags;

  logic                 w_any;
  logic [IDW-1:0]       w_gnt;
  logic [IDW-1:0]       w_idx;
  logic                 w_grant;
  logic                 w_timeout;
  logic [31:0]          w_a_arr [NUM_REQ];
  logic [31:0]          w_b_arr [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_a_arr[k] = req_a_i[32*k +: 32];
      w_b_arr[k] = req_b_i[32*k +: 32];
    end
  end

  // First requester strictly after the last grant, wrapping around.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = IDW'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_any && req_valid_i[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  // A done still high from the previous operation must not look like completion of the next.
  assign w_grant   = (r_state == S_IDLE) && !mul_done_i && w_any;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_BUSY;
      S_BUSY:  if (mul_done_i || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_ready      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_product    <= '0;
      r_flags      <= '0;
    end else begin
      r_ready <= '0;
      if (w_grant) begin
        r_ready      <= NUM_REQ'(1) << w_gnt;
        r_a          <= w_a_arr[w_gnt];
        r_b          <= w_b_arr[w_gnt];
        r_last_grant <= w_gnt;
        r_id         <= w_gnt;
        r_cnt        <= '0;
      end
      // Done has priority over the watchdog on the same edge.
      if (r_state == S_BUSY) begin
        if (mul_done_i) begin
          r_product <= mul_product_i;
          r_flags   <= {1'b0, mul_flags_i};
        end else if (w_timeout) begin
          r_product <= '0;
          r_flags   <= 5'b10000;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign req_ready_o    = r_ready;
  assign resp_valid_o   = (r_state == S_RESP);
  assign resp_id_o      = r_id;
  assign resp_product_o = r_product;
  assign resp_flags_o   = r_flags;
  assign mul_start_o    = (r_state == S_BUSY);
  assign mul_a_o        = r_a;
  assign mul_b_o        = r_b;
  assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: mock multiplier, transaction-level reference model, directed scenarios.
module tb_fp_mul_arbiter;
  localparam int NUM = 4;
  localparam int TO  = 64;

  logic              clk;
  logic              rst;
  logic [NUM-1:0]    req_valid;
  logic [32*NUM-1:0] req_a;
  logic [32*NUM-1:0] req_b;
  logic [NUM-1:0]    req_ready;
  logic              resp_valid;
  logic [1:0]        resp_id;
  logic [31:0]       resp_product;
  logic [4:0]        resp_flags;
  logic              mul_start;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_done;
  logic [31:0]       mul_product;
  logic [3:0]        mul_flags;
  logic              busy;

  fp_mul_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_id_o(resp_id),
    .resp_product_o(resp_product), .resp_flags_o(resp_flags),
    .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_done_i(mul_done), .mul_product_i(mul_product), .mul_flags_i(mul_flags),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Mock multiplier: done rises mock_lat cycles after start, held until start drops.
  int          mock_lat   = 3;
  bit          mock_never = 1'b0;
  bit          force_done = 1'b0;
  logic [31:0] mock_prod  = '0;
  logic [3:0]  mock_flags = '0;
  int          mock_cnt;
  logic        mock_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mock_cnt  <= 0;
      mock_done <= 1'b0;
    end else if (!mul_start) begin
      mock_cnt  <= 0;
      mock_done <= 1'b0;
    end else if (!mock_done && !mock_never) begin
      if (mock_cnt == mock_lat - 1) mock_done <= 1'b1;
      mock_cnt <= mock_cnt + 1;
    end
  end

  assign mul_done    = mock_done | force_done;
  assign mul_product = mock_prod;
  assign mul_flags   = mock_flags;

  // Reference model: round-robin choice plus expected response cycle per transaction.
  int          cyc = 0;
  int          m_last, m_gnext, m_resp_cyc;
  bit          m_pend;
  logic [31:0] m_a, m_b, m_na, m_nb, m_rprod, m_nprod;
  logic [4:0]  m_rflags, m_nflags;
  int          m_rid, m_nlat;
  bit          m_nto;
  int          glog[$];
  int          rlog[$];

  always @(negedge clk) begin
    logic [NUM-1:0] exp_ready;
    bit exp_resp;
    cyc++;
    if (rst) begin
      m_last = NUM - 1; m_gnext = -1; m_pend = 0;
      m_a = '0; m_b = '0; m_rid = 0; m_rprod = '0; m_rflags = '0;
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_start", mul_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_product", resp_product, 0);
      chk("rst_flags", resp_flags, 0);
    end else begin
      exp_ready = '0;
      if (m_gnext >= 0) begin
        exp_ready  = NUM'(1) << m_gnext;
        m_last     = m_gnext;
        m_rid      = m_gnext;
        m_a        = m_na;
        m_b        = m_nb;
        m_pend     = 1;
        m_resp_cyc = m_nto ? cyc + TO : cyc + m_nlat + 1;
        glog.push_back(m_gnext);
      end
      exp_resp = m_pend && (cyc == m_resp_cyc);
      if (exp_resp) begin
        m_rprod  = m_nto ? 32'h0 : m_nprod;
        m_rflags = m_nto ? 5'b10000 : m_nflags;
      end
      chk("ready", req_ready, exp_ready);
      chk("resp_valid", resp_valid, exp_resp);
      chk("busy", busy, m_pend);
      chk("start", mul_start, m_pend && !exp_resp);
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("resp_id", resp_id, m_rid);
      chk("resp_product", resp_product, m_rprod);
      chk("resp_flags", resp_flags, m_rflags);
      if (exp_resp) begin
        m_pend = 0;
        rlog.push_back(m_rid);
      end
      m_gnext = -1;
      if (!m_pend && !exp_resp && !mul_done) begin
        for (int i = 1; i <= NUM; i++)
          if (m_gnext < 0 && req_valid[(m_last + i) % NUM]) m_gnext = (m_last + i) % NUM;
      end
      if (m_gnext >= 0) begin
        m_na     = req_a[32*m_gnext +: 32];
        m_nb     = req_b[32*m_gnext +: 32];
        m_nlat   = mock_lat;
        m_nto    = mock_never || (mock_lat + 1 > TO);
        m_nprod  = mock_prod;
        m_nflags = {1'b0, mock_flags};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (req_ready[k]) begin
        ok = 1;
        break;
      end
    end
    chk("ready_seen", ok, 1);
  endtask

  task automatic wait_resp(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (resp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_order[6];
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #1 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single request: 7.5 * 2.2
    mock_lat = 3; mock_prod = 32'h41840000; mock_flags = 4'h0;
    req_a[31:0] = 32'h40F00000; req_b[31:0] = 32'h400CCCCD; req_valid = 4'b0001;
    wait_ready(0);
    req_valid = '0;
    req_a[31:0] = 32'hDEADBEEF;
    chk("t1_mul_a", mul_a, 32'h40F00000);
    wait_resp(n);
    chk("t1_latency", n, 4);
    chk("t1_id", resp_id, 0);
    chk("t1_product", resp_product, 32'h41840000);
    chk("t1_flags", resp_flags, 5'b00000);
    step();

    // All four continuously from reset
    rst = 1'b1; step(); step(); rst = 1'b0;
    glog.delete(); rlog.delete();
    mock_lat = 2; mock_prod = 32'h40C00000;
    req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_b = {32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000};
    req_valid = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      wait_resp(n);
      chk("t2_resp_seen", n > 0, 1);
    end
    req_valid = '0;
    step(); step();
    exp_order = '{0, 1, 2, 3, 0, 1};
    chk("t2_grant_count", glog.size(), 6);
    chk("t2_resp_count", rlog.size(), 6);
    for (int t = 0; t < 6 && t < glog.size() && t < rlog.size(); t++) begin
      chk("t2_grant_order", glog[t], exp_order[t]);
      chk("t2_resp_id", rlog[t], exp_order[t]);
    end

    // NaN flag pass-through
    mock_lat = 3; mock_prod = 32'h7FC00000; mock_flags = 4'b1000;
    req_a[63:32] = 32'h7FC00000; req_b[63:32] = 32'h3F800000; req_valid = 4'b0010;
    wait_ready(1);
    req_valid = '0;
    wait_resp(n);
    chk("t3_flags", resp_flags, 5'b01000);
    chk("t3_id", resp_id, 1);
    mock_flags = 4'h0;
    step();

    // Timeout, then a normal transaction
    mock_never = 1'b1; req_valid = 4'b1000;
    wait_ready(3);
    req_valid = '0;
    wait_resp(n);
    chk("t4_timeout_cycles", n, 64);
    chk("t4_flags", resp_flags, 5'b10000);
    chk("t4_product", resp_product, 32'h0);
    mock_never = 1'b0; mock_lat = 3; mock_prod = 32'h3F800000;
    req_valid = 4'b0001;
    wait_ready(0);
    req_valid = '0;
    wait_resp(n);
    chk("t4_after_latency", n, 4);
    chk("t4_after_flags", resp_flags, 5'b00000);
    chk("t4_after_product", resp_product, 32'h3F800000);
    step();

    // Stale done holds off the next grant
    mock_lat = 2; req_valid = 4'b0010;
    wait_ready(1);
    req_valid = '0;
    wait_resp(n);
    force_done = 1'b1; req_valid = 4'b0100;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("t5_no_grant", req_ready, 4'b0000);
    end
    force_done = 1'b0;
    step();
    chk("t5_grant2", req_ready, 4'b0100);
    req_valid = '0;
    wait_resp(n);
    chk("t5_id", resp_id, 2);
    step();

    // Asynchronous reset in the middle of BUSY
    mock_lat = 10; req_valid = 4'b0100;
    wait_ready(2);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t6_busy_drop", busy, 0);
    chk("t6_start_drop", mul_start, 0);
    chk("t6_no_resp", resp_valid, 0);
    req_valid = 4'b0101;
    step(); step();
    rst = 1'b0;
    wait_ready(0);
    chk("t6_first_grant", req_ready, 4'b0001);
    req_valid = '0;
    wait_resp(n);
    chk("t6_resp_id", resp_id, 0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
